// File: rtl/sc_ndata_deserializer.sv
// sc_ndata_deserializer
// Recovers the NBITS-wide note data word (NDATA) from the sensor-board serial
// link. The three asynchronous link lines are synchronised into clk, edges of
// ser_clk / ser_cs_n are detected, bits are shifted MSB first, and the frame
// is checked before NDATA is updated. NDATA is forced to zero on link loss.
//
// Optional feature macro: SC_DESER_PARITY_EN
//   defined   : frames with odd parity over payload+parity bit are rejected
//   undefined : the parity bit is shifted in but ignored
module sc_ndata_deserializer #(
  parameter int NBITS       = 37,
  parameter int TIMEOUT     = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_clk,
  input  logic             ser_data,
  input  logic             ser_cs_n,
  output logic [NBITS-1:0] NDATA,
  output logic             ndata_valid,
  output logic             frame_err,
  output logic             link_up,
  output logic [15:0]      frame_count
);

  localparam int CW = $clog2(NBITS + 2);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_CNT = CW'(NBITS);
  localparam logic [TW-1:0] T_SAT    = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_EXP    = TW'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    CHECK    = 2'd2,
    WAIT_END = 2'd3
  } state_t;

  state_t state_r, state_s;

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic                   clk_prev_r;
  logic                   cs_prev_r;

  logic [NBITS:0]  shift_r;
  logic [CW-1:0]   bit_cnt_r;
  logic [TW-1:0]   tmo_cnt_r;

  logic sclk_s, sdata_s, scs_s;
  logic clk_rise_s, cs_rise_s, cs_fall_s;
  logic start_s, shift_en_s, short_err_s, accept_s, reject_s, parity_ok_s;

  // Even parity over payload and parity bit: XOR of all bits must be zero.
  function automatic logic even_parity_ok(input logic [NBITS:0] frame);
    even_parity_ok = ~(^frame);
  endfunction

  // Synchroniser chains and edge-detect stage; reset to 0 so a cs_n already
  // low when reset is released never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_r  <= '0;
      data_sync_r <= '0;
      cs_sync_r   <= '0;
      clk_prev_r  <= 1'b0;
      cs_prev_r   <= 1'b0;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ser_clk};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ser_data};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], ser_cs_n};
      clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
      cs_prev_r   <= cs_sync_r[SYNC_STAGES-1];
    end
  end

  assign sclk_s     = clk_sync_r[SYNC_STAGES-1];
  assign sdata_s    = data_sync_r[SYNC_STAGES-1];
  assign scs_s      = cs_sync_r[SYNC_STAGES-1];
  assign clk_rise_s = sclk_s & ~clk_prev_r;
  assign cs_rise_s  = scs_s & ~cs_prev_r;
  assign cs_fall_s  = ~scs_s & cs_prev_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; a cs_n rise in SHIFT wins over a same-cycle data edge.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cs_fall_s) state_s = SHIFT;
        else           state_s = IDLE;
      end
      SHIFT: begin
        if (cs_rise_s)                             state_s = IDLE;
        else if (clk_rise_s && bit_cnt_r == LAST_CNT) state_s = CHECK;
        else                                       state_s = SHIFT;
      end
      CHECK: begin
        state_s = WAIT_END;
      end
      WAIT_END: begin
        // Level test also covers a cs_n rise that landed during CHECK.
        if (scs_s) state_s = IDLE;
        else       state_s = WAIT_END;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM output decode: control strobes for the datapath.
  always_comb begin
    start_s     = 1'b0;
    shift_en_s  = 1'b0;
    short_err_s = 1'b0;
    accept_s    = 1'b0;
    reject_s    = 1'b0;
`ifdef SC_DESER_PARITY_EN
    parity_ok_s = even_parity_ok(shift_r);
`else
    parity_ok_s = 1'b1;
`endif
    case (state_r)
      IDLE: begin
        start_s = cs_fall_s;
      end
      SHIFT: begin
        short_err_s = cs_rise_s;
        shift_en_s  = clk_rise_s & ~cs_rise_s;
      end
      CHECK: begin
        accept_s = parity_ok_s;
        reject_s = ~parity_ok_s;
      end
      WAIT_END: begin
        start_s = 1'b0;
      end
      default: begin
        start_s = 1'b0;
      end
    endcase
  end

  // Bit capture: clear at frame start, shift MSB first on each data edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r   <= '0;
      bit_cnt_r <= '0;
    end else if (start_s) begin
      shift_r   <= '0;
      bit_cnt_r <= '0;
    end else if (shift_en_s) begin
      shift_r   <= {shift_r[NBITS-1:0], sdata_s};
      bit_cnt_r <= bit_cnt_r + CW'(1);
    end else begin
      shift_r   <= shift_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Registered outputs and link timeout; acceptance has priority over expiry,
  // and the expiry clear fires only on the step into saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      NDATA       <= '0;
      ndata_valid <= 1'b0;
      frame_err   <= 1'b0;
      link_up     <= 1'b0;
      frame_count <= 16'd0;
      tmo_cnt_r   <= '0;
    end else begin
      ndata_valid <= accept_s;
      frame_err   <= short_err_s | reject_s;
      if (accept_s) begin
        NDATA       <= shift_r[NBITS:1];
        frame_count <= frame_count + 16'd1;
        tmo_cnt_r   <= '0;
        link_up     <= 1'b1;
      end else if (tmo_cnt_r != T_SAT) begin
        tmo_cnt_r <= tmo_cnt_r + TW'(1);
        if (tmo_cnt_r == T_EXP) begin
          link_up <= 1'b0;
          NDATA   <= '0;
        end
      end
    end
  end

endmodule
